// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: per-register pending-write counters gate issue on RAW/saturation, plus a drain FSM.
// Grant and stall are combinational from registered counters; counters, inflight and drain state update on the next edge.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_issue_valid,
    input  logic                             i_uses_rs1,
    input  logic [4:0]                       i_rs1,
    input  logic                             i_uses_rs2,
    input  logic [4:0]                       i_rs2,
    input  logic                             i_rd_we,
    input  logic [4:0]                       i_rd,
    input  logic                             i_ds_stall,
    input  logic                             i_flush,
    input  logic                             i_wb_en,
    input  logic [4:0]                       i_wb_rd,
    input  logic                             i_drain_req,
    output logic                             o_issue_grant,
    output logic                             o_hazard_stall,
    output logic [NUM_REGS-1:0]              o_busy_vec,
    output logic [$clog2(NUM_REGS)+CNT_W-1:0] o_inflight,
    output logic                             o_drain_done,
    output logic                             o_err_underflow
);
    localparam int IW = $clog2(NUM_REGS) + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic               r_drain_done;
    logic               r_err_underflow;
    logic [IW-1:0]      r_inflight;
    logic [CNT_W-1:0]   r_cnt [NUM_REGS];

    logic               w_haz;
    logic               w_drain_blk;
    logic               w_alloc;
    logic               w_wb_hit;
    logic               w_retire;
    logic               w_underflow;
    logic [NUM_REGS-1:0] w_inc_vec;
    logic [NUM_REGS-1:0] w_dec_vec;

    // No writeback bypass: a register being written back this cycle still blocks its readers.
    assign w_haz = (i_uses_rs1 & (i_rs1 != 5'd0) & (r_cnt[i_rs1] != '0))
                 | (i_uses_rs2 & (i_rs2 != 5'd0) & (r_cnt[i_rs2] != '0))
                 | (i_rd_we    & (i_rd  != 5'd0) & (r_cnt[i_rd]  == CNT_MAX));

    assign w_drain_blk    = (r_state != S_RUN) | i_drain_req;
    assign o_hazard_stall = i_issue_valid & (w_haz | w_drain_blk);
    assign o_issue_grant  = i_issue_valid & ~o_hazard_stall & ~i_ds_stall & ~i_flush;

    assign w_alloc     = o_issue_grant & i_rd_we & (i_rd != 5'd0);
    assign w_wb_hit    = i_wb_en & (i_wb_rd != 5'd0);
    assign w_retire    = w_wb_hit & (r_cnt[i_wb_rd] != '0);
    assign w_underflow = w_wb_hit & (r_cnt[i_wb_rd] == '0);

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_alloc)  w_inc_vec[i_rd]    = 1'b1;
        if (w_retire) w_dec_vec[i_wb_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_inc_vec[r] && !w_dec_vec[r])
                    r_cnt[r] <= r_cnt[r] + 1'b1;
                else if (w_dec_vec[r] && !w_inc_vec[r])
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_alloc && !w_retire)
                r_inflight <= r_inflight + 1'b1;
            else if (w_retire && !w_alloc)
                r_inflight <= r_inflight - 1'b1;
            if (w_underflow)
                r_err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_drain_done <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_drain_req) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!i_drain_req) begin
                        r_state <= S_RUN;
                    end else if (r_inflight == '0) begin
                        r_state      <= S_DONE;
                        r_drain_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!i_drain_req) begin
                        r_state      <= S_RUN;
                        r_drain_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_RUN;
                    r_drain_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) o_busy_vec[r] = (r_cnt[r] != '0);
    end

    assign o_inflight      = r_inflight;
    assign o_drain_done    = r_drain_done;
    assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomised and directed bench for issue_scoreboard with a queue-based scoreboard and an abstract register model.
module tb_issue_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_issue_valid = 1'b0, i_uses_rs1 = 1'b0, i_uses_rs2 = 1'b0, i_rd_we = 1'b0;
    logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0, i_wb_rd = '0;
    logic        i_ds_stall = 1'b0, i_flush = 1'b0, i_wb_en = 1'b0, i_drain_req = 1'b0;
    logic        o_issue_grant, o_hazard_stall, o_drain_done, o_err_underflow;
    logic [31:0] o_busy_vec;
    logic [6:0]  o_inflight;

    issue_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_issue_valid(i_issue_valid), .i_uses_rs1(i_uses_rs1), .i_rs1(i_rs1),
        .i_uses_rs2(i_uses_rs2), .i_rs2(i_rs2), .i_rd_we(i_rd_we), .i_rd(i_rd),
        .i_ds_stall(i_ds_stall), .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd),
        .i_drain_req(i_drain_req),
        .o_issue_grant(o_issue_grant), .o_hazard_stall(o_hazard_stall), .o_busy_vec(o_busy_vec),
        .o_inflight(o_inflight), .o_drain_done(o_drain_done), .o_err_underflow(o_err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          grant;
        bit          stall;
        logic [31:0] busy;
        int          inflight;
        bit          done;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: pending writes per register, drain mode 0=run 1=draining 2=done.
    int   m_cnt [32];
    int   m_mode;
    bit   m_err;

    function automatic int m_total();
        int s = 0;
        for (int r = 0; r < 32; r++) s += m_cnt[r];
        return s;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] > 0);
        return b;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_mode = 0;
        m_err  = 1'b0;
    endtask

    task automatic push_exp(input bit grant, input bit stall);
        exp_t e;
        e.grant = grant; e.stall = stall; e.busy = m_busy();
        e.inflight = m_total(); e.done = (m_mode == 2); e.err = m_err;
        q.push_back(e);
    endtask

    task automatic step(input bit v, input bit u1, input int s1, input bit u2, input int s2,
                        input bit we, input int rd, input bit ds, input bit fl,
                        input bit wbe, input int wbr, input bit dr);
        bit haz, stall, grant;
        int total;
        @(negedge clk);
        i_issue_valid = v; i_uses_rs1 = u1; i_rs1 = 5'(s1); i_uses_rs2 = u2; i_rs2 = 5'(s2);
        i_rd_we = we; i_rd = 5'(rd); i_ds_stall = ds; i_flush = fl;
        i_wb_en = wbe; i_wb_rd = 5'(wbr); i_drain_req = dr;
        haz = (u1 && s1 != 0 && m_cnt[s1] > 0) || (u2 && s2 != 0 && m_cnt[s2] > 0)
           || (we && rd != 0 && m_cnt[rd] >= 3);
        stall = v && (haz || m_mode != 0 || dr);
        grant = v && !stall && !ds && !fl;
        push_exp(grant, stall);
        total = m_total();
        if (wbe && wbr != 0) begin
            if (m_cnt[wbr] > 0) m_cnt[wbr]--;
            else m_err = 1'b1;
        end
        if (grant && we && rd != 0) m_cnt[rd]++;
        case (m_mode)
            0: if (dr) m_mode = 1;
            1: if (!dr) m_mode = 0; else if (total == 0) m_mode = 2;
            default: if (!dr) m_mode = 0;
        endcase
    endtask

    task automatic idle(input bit wbe, input int wbr, input bit dr);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, wbe, wbr, dr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_issue_valid = 0; i_uses_rs1 = 0; i_uses_rs2 = 0; i_rd_we = 0; i_ds_stall = 0;
        i_flush = 0; i_wb_en = 0; i_drain_req = 0;
        model_clear();
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant",    o_issue_grant,   e.grant);
                chk("stall",    o_hazard_stall,  e.stall);
                chk("busy_vec", o_busy_vec,      e.busy);
                chk("inflight", o_inflight,      e.inflight);
                chk("done",     o_drain_done,    e.done);
                chk("underflow", o_err_underflow, e.err);
            end
        end
    end

    function automatic int pick_reg();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            4: return 7;
            default: return 9;
        endcase
    endfunction

    initial begin : driver
        bit dr = 1'b0;
        model_clear();
        do_reset();
        // RAW on x5: stall until the cycle after writeback.
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 1, 6, 0, 0, 1, 5, 0);
        step(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        idle(1, 6, 0);
        // Saturate x7.
        repeat (4) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        repeat (3) idle(1, 7, 0);
        // Allocate and retire x3 together.
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 3, 0);
        idle(1, 3, 0);
        // Flush then grant, downstream stall then grant.
        step(1, 1, 1, 0, 0, 1, 4, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        idle(1, 4, 0);
        // Underflow and x0 handling.
        idle(1, 9, 0);
        repeat (5) step(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        // Drain with two writes in flight.
        step(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 12, 0, 0, 1, 10, 1);
        step(1, 0, 0, 0, 0, 1, 12, 0, 0, 1, 11, 1);
        repeat (3) step(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
        idle(1, 12, 0);
        // Drain abandoned while writes are pending.
        step(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) dr = !dr;
            if (c == 1500) begin
                do_reset();
                dr = 1'b0;
            end
            step($urandom_range(0, 9) < 8, $urandom_range(0, 1), pick_reg(),
                 $urandom_range(0, 1), pick_reg(), $urandom_range(0, 3) != 0, pick_reg(),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 4, pick_reg(), dr);
        end
        repeat (3) @(negedge clk);
        #5;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
